// File: rtl/l2_meta_pkg.sv
// Shared types and tree pseudo-LRU helpers for the L2 metadata array.
// Helpers work on max-width vectors; callers zero-extend and truncate.
package l2_meta_pkg;

    typedef enum logic {IDLE, CLEAR} fsm_state_t;

    localparam int MAX_WAYS  = 64;
    localparam int MAX_WAY_W = 6;

    function automatic int tree_levels(input int ways);
        int levels;
        levels = 0;
        for (int l = 0; l < MAX_WAY_W; l++)
            if ((1 << l) < ways) levels++;
        return levels;
    endfunction

    // Lowest invalid way wins; otherwise follow the tree (0 = left, 1 = right).
    function automatic logic [MAX_WAY_W-1:0] plru_victim(
        input logic [MAX_WAYS-2:0] bits,
        input logic [MAX_WAYS-1:0] valid,
        input int                  ways
    );
        logic [MAX_WAY_W-1:0] v;
        logic                 found;
        int                   node;
        v     = '0;
        found = 1'b0;
        for (int w = 0; w < MAX_WAYS; w++) begin
            if (w < ways && !found && !valid[w]) begin
                v     = MAX_WAY_W'(w);
                found = 1'b1;
            end
        end
        if (!found) begin
            node = 0;
            for (int l = 0; l < MAX_WAY_W; l++)
                if (l < tree_levels(ways)) node = 2 * node + 1 + int'(bits[node]);
            v = MAX_WAY_W'(node - (ways - 1));
        end
        return v;
    endfunction

    // Each node on the path to way points away from it.
    function automatic logic [MAX_WAYS-2:0] plru_update(
        input logic [MAX_WAYS-2:0]  bits,
        input logic [MAX_WAY_W-1:0] way,
        input int                   ways
    );
        logic [MAX_WAYS-2:0] nb;
        int                  node;
        int                  levels;
        logic                dir;
        nb     = bits;
        node   = 0;
        levels = tree_levels(ways);
        for (int l = 0; l < MAX_WAY_W; l++) begin
            if (l < levels) begin
                dir      = way[levels - 1 - l];
                nb[node] = ~dir;
                node     = 2 * node + 1 + int'(dir);
            end
        end
        return nb;
    endfunction

endpackage

// File: rtl/l2_plru_tree.sv
// Combinational tree PLRU for one set: victim choice and post-touch bits.
module l2_plru_tree
    import l2_meta_pkg::*;
#(
    parameter int num_ways = 4,
    parameter int s_way    = $clog2(num_ways)
) (
    input  logic [num_ways-2:0] bits,
    input  logic [num_ways-1:0] valid,
    input  logic [s_way-1:0]    way,
    output logic [s_way-1:0]    victim,
    output logic [num_ways-2:0] next_bits
);

    always_comb begin
        victim    = s_way'(plru_victim((MAX_WAYS-1)'(bits), MAX_WAYS'(valid), num_ways));
        next_bits = (num_ways-1)'(plru_update((MAX_WAYS-1)'(bits), MAX_WAY_W'(way), num_ways));
    end

endmodule

// File: rtl/l2_meta_array.sv
// L2 metadata store: per-way {valid, dirty, tag} plus tree PLRU per set,
// registered lookup with write-first forwarding and a set-by-set clear sweep.
module l2_meta_array
    import l2_meta_pkg::*;
#(
    parameter int s_index  = 4,
    parameter int s_tag    = 23,
    parameter int num_ways = 4,
    localparam int s_way   = $clog2(num_ways)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               read,
    input  logic [s_index-1:0] rindex,
    input  logic [s_tag-1:0]   rtag,
    input  logic               load,
    input  logic [s_index-1:0] windex,
    input  logic [s_way-1:0]   wway,
    input  logic [s_tag-1:0]   wtag,
    input  logic               wvalid,
    input  logic               wdirty,
    input  logic               touch,
    input  logic [s_index-1:0] tindex,
    input  logic [s_way-1:0]   tway,
    input  logic               clear_req,
    output logic               busy,
    output logic               rvalid,
    output logic               hit,
    output logic [s_way-1:0]   hit_way,
    output logic [s_way-1:0]   victim_way,
    output logic [s_tag-1:0]   victim_tag,
    output logic               victim_dirty
);

    localparam int num_sets = 1 << s_index;

    logic [num_ways-1:0] valid_q [num_sets];
    logic [num_ways-1:0] dirty_q [num_sets];
    logic [s_tag-1:0]    tag_q   [num_sets][num_ways];
    logic [num_ways-2:0] plru_q  [num_sets];

    fsm_state_t         state;
    logic [s_index-1:0] sweep_idx;

    logic load_en, touch_en, read_en;
    assign load_en  = load  && (state == IDLE);
    assign touch_en = touch && (state == IDLE);
    assign read_en  = read  && (state == IDLE) && !clear_req;

    logic [num_ways-1:0] fwd_way, eff_valid, eff_dirty;
    logic [s_tag-1:0]    eff_tag [num_ways];
    logic [num_ways-2:0] eff_plru, touch_next;
    logic                hit_c;
    logic [s_way-1:0]    hit_way_c, victim_c;
    logic [s_way-1:0]    unused_touch_victim;
    logic [num_ways-2:0] unused_lookup_next;

    l2_plru_tree #(.num_ways(num_ways), .s_way(s_way)) u_touch_tree (
        .bits      (plru_q[tindex]),
        .valid     (valid_q[tindex]),
        .way       (tway),
        .victim    (unused_touch_victim),
        .next_bits (touch_next)
    );

    l2_plru_tree #(.num_ways(num_ways), .s_way(s_way)) u_lookup_tree (
        .bits      (eff_plru),
        .valid     (eff_valid),
        .way       ('0),
        .victim    (victim_c),
        .next_bits (unused_lookup_next)
    );

    // Same-cycle load/touch to the looked-up set is visible to the lookup.
    always_comb begin
        for (int w = 0; w < num_ways; w++) begin
            fwd_way[w]   = load_en && (windex == rindex) && (wway == s_way'(w));
            eff_valid[w] = fwd_way[w] ? wvalid : valid_q[rindex][w];
            eff_dirty[w] = fwd_way[w] ? wdirty : dirty_q[rindex][w];
            eff_tag[w]   = fwd_way[w] ? wtag   : tag_q[rindex][w];
        end
        eff_plru = (touch_en && (tindex == rindex)) ? touch_next : plru_q[rindex];
    end

    always_comb begin
        hit_c     = 1'b0;
        hit_way_c = '0;
        for (int w = num_ways - 1; w >= 0; w--) begin
            if (eff_valid[w] && (eff_tag[w] == rtag)) begin
                hit_c     = 1'b1;
                hit_way_c = s_way'(w);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            busy         <= 1'b0;
            sweep_idx    <= '0;
            rvalid       <= 1'b0;
            hit          <= 1'b0;
            hit_way      <= '0;
            victim_way   <= '0;
            victim_tag   <= '0;
            victim_dirty <= 1'b0;
            for (int s = 0; s < num_sets; s++) begin
                valid_q[s] <= '0;
                dirty_q[s] <= '0;
                plru_q[s]  <= '0;
                for (int w = 0; w < num_ways; w++) tag_q[s][w] <= '0;
            end
        end else begin
            rvalid <= read_en;
            if (read_en) begin
                hit          <= hit_c;
                hit_way      <= hit_way_c;
                victim_way   <= victim_c;
                victim_tag   <= eff_tag[victim_c];
                victim_dirty <= eff_valid[victim_c] & eff_dirty[victim_c];
            end
            case (state)
                IDLE: begin
                    if (load_en) begin
                        valid_q[windex][wway] <= wvalid;
                        dirty_q[windex][wway] <= wdirty;
                        tag_q[windex][wway]   <= wtag;
                    end
                    if (touch_en) plru_q[tindex] <= touch_next;
                    if (clear_req) begin
                        state     <= CLEAR;
                        busy      <= 1'b1;
                        sweep_idx <= '0;
                    end
                end
                CLEAR: begin
                    // Tags survive the sweep; only state bits are dropped.
                    valid_q[sweep_idx] <= '0;
                    dirty_q[sweep_idx] <= '0;
                    plru_q[sweep_idx]  <= '0;
                    sweep_idx          <= sweep_idx + s_index'(1);
                    if (sweep_idx == s_index'(num_sets - 1)) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
